// File: rtl/lectura_rtc.sv
// lectura_rtc: reads the seconds, minutes and hours registers from the RTC over
// the multiplexed AD bus. Each register takes an address-write phase followed by
// a data-read phase. The three values are presented together with a one-cycle
// valid pulse. All bus outputs are registered from the next state, so the output
// values always match the state the block has just entered.
module lectura_rtc #(
  parameter int          PULSE_CYC = 5,
  parameter int          GAP_CYC   = 8,
  parameter logic [7:0]  ADDR_SEG  = 8'h21,
  parameter logic [7:0]  ADDR_MIN  = 8'h22,
  parameter logic [7:0]  ADDR_HOR  = 8'h23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic       ad,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] ADout,
  output logic       ad_oe,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, A_GAP,
    D_SETUP, D_PULSE, D_HOLD, D_GAP, DONE
  } state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] idx, idx_nx;
  logic [7:0] sh_seg, sh_min, sh_hor;

  logic       n_ad, n_cs, n_rd, n_wr, n_oe;
  logic [7:0] n_dout, addr_nx;

  // Remaining-cycle count loaded on entry to a state: multi-cycle states count
  // down to zero, single-cycle states load zero.
  function automatic logic [3:0] load_of(input state_t s);
    case (s)
      A_PULSE, D_PULSE: load_of = PULSE_LD;
      A_GAP, D_GAP:     load_of = GAP_LD;
      default:          load_of = 4'd0;
    endcase
  endfunction

  // State, phase counter and register index.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic. DONE chains straight into a new read when start is still
  // high so continuous polling has no idle bubble between reads.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE:    if (start) begin state_nx = A_SETUP; idx_nx = 2'd0; end
      A_SETUP: state_nx = A_PULSE;
      A_PULSE: if (cnt == 4'd0) state_nx = A_HOLD;
      A_HOLD:  state_nx = A_GAP;
      A_GAP:   if (cnt == 4'd0) state_nx = D_SETUP;
      D_SETUP: state_nx = D_PULSE;
      D_PULSE: if (cnt == 4'd0) state_nx = D_HOLD;
      D_HOLD:  state_nx = D_GAP;
      D_GAP: begin
        if (cnt == 4'd0) begin
          if (idx == 2'd2) state_nx = DONE;
          else begin
            state_nx = A_SETUP;
            idx_nx   = idx + 2'd1;
          end
        end
      end
      DONE: begin
        if (start) begin state_nx = A_SETUP; idx_nx = 2'd0; end
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Phase counter reloads on every state change and never wraps in a state.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state)  cnt_nx = load_of(state_nx);
    else if (cnt != 4'd0)   cnt_nx = cnt - 4'd1;
  end

  // Bus values for the state being entered.
  always_comb begin
    case (idx_nx)
      2'd0:    addr_nx = ADDR_SEG;
      2'd1:    addr_nx = ADDR_MIN;
      default: addr_nx = ADDR_HOR;
    endcase
    n_ad   = 1'b1;
    n_cs   = 1'b1;
    n_rd   = 1'b1;
    n_wr   = 1'b1;
    n_oe   = 1'b0;
    n_dout = 8'hff;
    case (state_nx)
      A_SETUP, A_HOLD: begin
        n_ad = 1'b0; n_cs = 1'b0; n_oe = 1'b1; n_dout = addr_nx;
      end
      A_PULSE: begin
        n_ad = 1'b0; n_cs = 1'b0; n_oe = 1'b1; n_dout = addr_nx; n_wr = 1'b0;
      end
      D_SETUP: n_cs = 1'b0;
      D_PULSE: begin n_cs = 1'b0; n_rd = 1'b0; end
      default: ;
    endcase
  end

  // Registered outputs; reset forces the bus idle on the very next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      ad    <= 1'b1;
      cs    <= 1'b1;
      rd    <= 1'b1;
      wr    <= 1'b1;
      ad_oe <= 1'b0;
      ADout <= 8'hff;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ad    <= n_ad;
      cs    <= n_cs;
      rd    <= n_rd;
      wr    <= n_wr;
      ad_oe <= n_oe;
      ADout <= n_dout;
      valid <= (state_nx == DONE);
      busy  <= (state_nx != IDLE);
    end
  end

  // Shadow capture at the end of the last read-strobe cycle; results are only
  // published on entry to DONE so a partial read never disturbs them.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_seg   <= 8'h00;
      sh_min   <= 8'h00;
      sh_hor   <= 8'h00;
      segundos <= 8'h00;
      minutos  <= 8'h00;
      horas    <= 8'h00;
    end else begin
      if (state == D_PULSE && cnt == 4'd0) begin
        case (idx)
          2'd0:    sh_seg <= ad_in;
          2'd1:    sh_min <= ad_in;
          default: sh_hor <= ad_in;
        endcase
      end
      if (state_nx == DONE) begin
        segundos <= sh_seg;
        minutos  <= sh_min;
        horas    <= sh_hor;
      end
    end
  end

endmodule

// File: tb/tb_lectura_rtc.sv
// Directed bench for lectura_rtc with a small RTC bus model and protocol monitor.
module tb_lectura_rtc;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [7:0] ad_in;
  logic       ad, cs, rd, wr, ad_oe, valid, busy;
  logic [7:0] ADout, segundos, minutos, horas;

  int n_chk = 0;
  int n_err = 0;

  lectura_rtc dut (
    .clock(clock), .reset(reset), .start(start), .ad_in(ad_in),
    .ad(ad), .cs(cs), .rd(rd), .wr(wr), .ADout(ADout), .ad_oe(ad_oe),
    .segundos(segundos), .minutos(minutos), .horas(horas),
    .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // RTC model: latches the address seen while wr is low, returns register
  // contents while rd is low and random junk otherwise.
  logic [7:0] m_seg, m_min, m_hor, cur_addr, junk;
  logic [7:0] rdata;

  always @(posedge clock) if (wr === 1'b0) cur_addr <= ADout;
  always @(negedge clock) junk = 8'($urandom);

  always_comb begin
    case (cur_addr)
      8'h21:   rdata = m_seg;
      8'h22:   rdata = m_min;
      8'h23:   rdata = m_hor;
      default: rdata = 8'hee;
    endcase
  end
  assign ad_in = (rd === 1'b0) ? rdata : junk;

  // Protocol monitor.
  int         viol = 0;
  int         vcount = 0;
  int         wr_run = 0, rd_run = 0;
  logic       wr_prev = 1'b1;
  logic [7:0] addrs[$];
  int         wr_lens[$], rd_lens[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (!wr && !rd)          viol++;
      if (ad_oe && !rd)        viol++;
      if (!wr && ad)           viol++;
      if (!ad_oe && ADout !== 8'hff) viol++;
      if (!wr) begin
        if (wr_prev) addrs.push_back(ADout);
        else if (ADout !== addrs[$]) viol++;
        wr_run++;
      end else if (wr_run != 0) begin
        wr_lens.push_back(wr_run);
        wr_run = 0;
      end
      if (!rd) rd_run++;
      else if (rd_run != 0) begin
        rd_lens.push_back(rd_run);
        rd_run = 0;
      end
      if (valid) vcount++;
    end
    wr_prev = wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one sample edge (edge 0) and count edges until valid.
  // Optionally re-pulse start after edge extra_at while the read is active.
  task automatic run_read(input int extra_at, output int edges);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 0;
    while (!valid && edges < 300) begin
      @(posedge clock); #1;
      edges++;
      start = (edges == extra_at);
    end
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_strobes"}, {28'd0, ad, cs, rd, wr}, 32'hf);
    chk({tag, "_oe"}, {31'd0, ad_oe}, 32'd0);
    chk({tag, "_dout"}, {24'd0, ADout}, 32'hff);
    chk({tag, "_vb"}, {30'd0, valid, busy}, 32'd0);
  endtask

  int e, v0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_seg = 8'h45; m_min = 8'h30; m_hor = 8'h12;
    cur_addr = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk_idle("reset");
    chk("reset_time", {8'd0, segundos, minutos, horas}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    addrs.delete(); wr_lens.delete(); rd_lens.delete();

    // 1: basic read
    run_read(-1, e);
    chk("t1_latency", e, 90);
    chk("t1_seg", {24'd0, segundos}, 32'h45);
    chk("t1_min", {24'd0, minutos}, 32'h30);
    chk("t1_hor", {24'd0, horas}, 32'h12);
    @(posedge clock); #1;
    chk("t1_after", {30'd0, valid, busy}, 32'd0);

    // 2: bus shape over that read
    chk("t2_naddr", addrs.size(), 3);
    chk("t2_nwr", wr_lens.size(), 3);
    chk("t2_nrd", rd_lens.size(), 3);
    if (addrs.size() == 3) begin
      chk("t2_addr0", {24'd0, addrs[0]}, 32'h21);
      chk("t2_addr1", {24'd0, addrs[1]}, 32'h22);
      chk("t2_addr2", {24'd0, addrs[2]}, 32'h23);
    end
    foreach (wr_lens[i]) chk("t2_wr_len", wr_lens[i], 5);
    foreach (rd_lens[i]) chk("t2_rd_len", rd_lens[i], 5);
    chk("t2_viol", viol, 0);

    // 3: reset in the middle of idx 1 read strobe
    m_seg = 8'h01; m_min = 8'h02; m_hor = 8'h03;
    v0 = vcount;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (48) @(posedge clock);
    #1;
    chk("t3_in_dpulse", {31'd0, rd}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_idle("t3_reset");
    chk("t3_outs", {8'd0, segundos, minutos, horas}, 32'd0);
    reset = 1'b0;
    repeat (120) @(posedge clock);
    #1;
    chk("t3_no_valid", vcount - v0, 0);
    chk("t3_outs_held", {8'd0, segundos, minutos, horas}, 32'd0);

    // 4 + 6: start during active read ignored; junk outside read strobe
    m_seg = 8'h59; m_min = 8'h07; m_hor = 8'h23;
    v0 = vcount;
    run_read(40, e);
    chk("t4_latency", e, 90);
    chk("t4_vals", {8'd0, segundos, minutos, horas}, 32'h590723);
    repeat (150) @(posedge clock);
    #1;
    chk("t4_one_valid", vcount - v0, 1);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // 5: start held high, back-to-back reads with new data
    m_seg = 8'h11; m_min = 8'h22; m_hor = 8'h08;
    start = 1'b1;
    @(posedge clock); #1;
    e = 0;
    while (!valid && e < 300) begin @(posedge clock); #1; e++; end
    chk("t5_first", e, 90);
    chk("t5_vals1", {8'd0, segundos, minutos, horas}, 32'h112208);
    m_seg = 8'h33; m_min = 8'h44; m_hor = 8'h09;
    do begin @(posedge clock); #1; e++; end while (!valid && e < 400);
    start = 1'b0;
    chk("t5_second", e, 181);
    chk("t5_vals2", {8'd0, segundos, minutos, horas}, 32'h334409);
    repeat (3) @(posedge clock);
    #1;
    chk("t5_stop", {31'd0, busy}, 32'd0);
    chk("final_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
